// File: rtl/mont_precompute.sv
// mont_precompute
//
// Setup stage for the Montgomery exponentiator. From an odd modulus N it
// derives, with R = 2^WIDTH:
//   n_prime = -N^-1 mod 2^WIDTH
//   r_mod   = R mod N   (Montgomery form of 1)
//   r2_mod  = R^2 mod N (domain-conversion constant)
// The block uses only shift/add/compare/subtract and has no multiplier. It
// spends 2*WIDTH iterations, one per clock.
//
// Configuration macro: MONT_PRECOMP_RMOD_EN
//   defined   -> r_mod port and its capture register exist
//   undefined -> r_mod port and its register are absent; all else unchanged
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   start    in   request, sampled only in IDLE
//   modulus  in   N, sampled on the edge that accepts start
//   busy     out  high while not in IDLE (including the done cycle)
//   done     out  one-cycle completion pulse
//   err      out  valid with done; N even or N == 1
//   n_prime  out  -N^-1 mod 2^WIDTH
//   r_mod    out  R mod N (MONT_PRECOMP_RMOD_EN only)
//   r2_mod   out  R^2 mod N
module mont_precompute #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] n_prime,
`ifdef MONT_PRECOMP_RMOD_EN
  output logic [WIDTH-1:0] r_mod,
`endif
  output logic [WIDTH-1:0] r2_mod
);

  // cnt spans 0 .. 2*WIDTH-1; bit_idx addresses one bit of the inverse path
  localparam int CW   = $clog2(2 * WIDTH);
  localparam int IDXW = $clog2(WIDTH);

  localparam logic [CW-1:0]    CNT_HALF = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0]    CNT_W    = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_C    = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] x;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   c_next;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] x_next;
  logic [IDXW-1:0]  bit_idx;
  logic             n_invalid;
  logic             err_hit;

  // One iteration of both datapaths. The residue path doubles c and reduces
  // once; because c < N always holds, t < 2N so a single conditional subtract
  // keeps it reduced. The inverse path (first WIDTH iterations only) forces
  // bit cnt of s = N*x to one, so after WIDTH steps N*x == -1 mod 2^WIDTH.
  always_comb begin
    t       = c << 1;
    n_ext   = {1'b0, n_reg};
    c_next  = (t >= n_ext) ? (t - n_ext) : t;
    bit_idx = cnt[IDXW-1:0];
    s_next  = s;
    x_next  = x;
    if (cnt < CNT_W && !s[bit_idx]) begin
      s_next = s + (n_reg << bit_idx);
      x_next = x | (ONE_W << bit_idx);
    end
  end

  // An even modulus has no inverse mod 2^WIDTH and N == 1 makes every
  // residue zero, so both are rejected on the first RUN cycle.
  always_comb begin
    n_invalid = !n_reg[0] || (n_reg == ONE_W);
    err_hit   = (state == RUN) && (cnt == '0) && n_invalid;
  end

  // Main FSM. done is raised on the edge after the results are captured, and
  // the block stays in FINISH through the done cycle so busy stays high and a
  // start during done is not taken. The error path raises done straight away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      n_prime <= '0;
      r2_mod  <= '0;
      n_reg   <= '0;
      c       <= '0;
      s       <= '0;
      x       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_reg <= modulus;
            cnt   <= '0;
            c     <= ONE_C;
            s     <= '0;
            x     <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (err_hit) begin
            err     <= 1'b1;
            n_prime <= '0;
            r2_mod  <= '0;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            c   <= c_next;
            s   <= s_next;
            x   <= x_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              n_prime <= x_next;
              r2_mod  <= c_next[WIDTH-1:0];
              state   <= FINISH;
            end
          end
        end
        FINISH: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MONT_PRECOMP_RMOD_EN
  // R mod N is the residue after the first WIDTH doublings; an error result
  // forces it to zero like the other outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mod <= '0;
    end else if (err_hit) begin
      r_mod <= '0;
    end else if (state == RUN && cnt == CNT_HALF) begin
      r_mod <= c_next[WIDTH-1:0];
    end
  end
`else
  // Without the r_mod output, R mod N exists only as the mid-run residue.
`endif

endmodule

// File: tb/tb_mont_precompute.sv
// tb_mont_precompute
//
// Directed bench for mont_precompute at WIDTH=8. Expected results come from
// a brute-force reference model and are queued when a start is accepted,
// then popped and compared when done appears.
module tb_mont_precompute;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] n_prime;
  logic [W-1:0] r2_mod;
`ifdef MONT_PRECOMP_RMOD_EN
  logic [W-1:0] r_mod;
`endif

  typedef struct {
    logic         err;
    logic [W-1:0] np;
    logic [W-1:0] r;
    logic [W-1:0] r2;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   edge_cnt;

  mont_precompute #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .n_prime (n_prime),
`ifdef MONT_PRECOMP_RMOD_EN
    .r_mod   (r_mod),
`endif
    .r2_mod  (r2_mod)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model by brute force over all candidate inverses
  function automatic exp_t model(input logic [W-1:0] n);
    exp_t e;
    int   nn;
    nn   = int'(n);
    e.err = (n[0] == 1'b0) || (n == 8'd1);
    e.np  = '0;
    e.r   = '0;
    e.r2  = '0;
    if (!e.err) begin
      for (int k = 0; k < 256; k++)
        if (((nn * k + 1) & 255) == 0) e.np = 8'(k);
      e.r  = 8'(256 % nn);
      e.r2 = 8'(65536 % nn);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Drive start for one accepting edge, then scramble the modulus input
  task automatic applyStimulus(input logic [W-1:0] n);
    start   = 1'b1;
    modulus = n;
    tick();
    edge_cnt = 0;
    start    = 1'b0;
    modulus  = 8'($urandom);
    sb.push_back(model(n));
  endtask

  // Wait (bounded) for done, compare against the oldest queued result,
  // then step into the following IDLE cycle
  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    lat = e.err ? 1 : 2 * W + 1;
    while (done !== 1'b1 && edge_cnt < 40) tick();
    chk({tag, "_done"},    32'(done),    32'd1);
    chk({tag, "_latency"}, 32'(edge_cnt), 32'(lat));
    chk({tag, "_busy"},    32'(busy),    32'd1);
    chk({tag, "_err"},     32'(err),     32'(e.err));
    chk({tag, "_nprime"},  32'(n_prime), 32'(e.np));
`ifdef MONT_PRECOMP_RMOD_EN
    chk({tag, "_rmod"},    32'(r_mod),   32'(e.r));
`endif
    chk({tag, "_r2mod"},   32'(r2_mod),  32'(e.r2));
    tick();
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    modulus  = '0;

    // Reset state
    #12;
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_done",   32'(done),    32'd0);
    chk("rst_err",    32'(err),     32'd0);
    chk("rst_nprime", 32'(n_prime), 32'd0);
    chk("rst_r2mod",  32'(r2_mod),  32'd0);
`ifdef MONT_PRECOMP_RMOD_EN
    chk("rst_rmod",   32'(r_mod),   32'd0);
`endif
    #10 rst = 1'b0;
    tick();

    // Basic run with N = 0xF1; busy must be up mid-run
    applyStimulus(8'hF1);
    tick();
    tick();
    chk("f1_busy_mid", 32'(busy), 32'd1);
    checkOutput("f1");

    // N = 0xFF, then N = 0x03 back-to-back in the first IDLE cycle
    applyStimulus(8'hFF);
    checkOutput("ff");
    applyStimulus(8'h03);
    checkOutput("n03");

    // Invalid moduli: even, and one
    applyStimulus(8'h10);
    checkOutput("even");
    applyStimulus(8'h01);
    checkOutput("one");

    // A second start at cnt=5 must be ignored
    applyStimulus(8'hF1);
    for (int i = 0; i < 5; i++) tick();
    start   = 1'b1;
    modulus = 8'h03;
    tick();
    start = 1'b0;
    checkOutput("ignore_start");

    // Reset at cnt=9: everything clears at once and no done follows
    applyStimulus(8'hF1);
    for (int i = 0; i < 9; i++) tick();
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("midrst_busy",   32'(busy),    32'd0);
    chk("midrst_done",   32'(done),    32'd0);
    chk("midrst_nprime", 32'(n_prime), 32'd0);
    chk("midrst_r2mod",  32'(r2_mod),  32'd0);
`ifdef MONT_PRECOMP_RMOD_EN
    chk("midrst_rmod",   32'(r_mod),   32'd0);
`endif
    #3 rst = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0) chk("midrst_no_done", 32'(done), 32'd0);
      tick();
    end
    chk("midrst_idle", 32'(busy), 32'd0);
    applyStimulus(8'hF1);
    checkOutput("after_rst");

    // A couple of random odd moduli
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'($urandom_range(1, 127) * 2 + 1));
      checkOutput("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
